// File: rtl/fetch_redirect_arbiter_pkg.sv
// Shared redirect types: exec mask, PC and the packet held in the fetch redirect slot.
// Also holds the default requester count and the slot state encoding.
package fetch_redirect_arbiter_pkg;
  localparam int N_SRC_DEF  = 4;
  localparam int MASK_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  typedef logic [MASK_W_DEF-1:0] execution_mask_t;
  typedef logic [ADDR_W_DEF-1:0] memory_address_t;

  typedef struct packed {
    execution_mask_t exec_mask;
    memory_address_t newpc;
  } redirect_pkt_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/fetch_redirect_arbiter_rr_picker.sv
// Round-robin picker: lowest index at or after ptr (wrapping) wins.
// Purely combinational, zero latency; no backpressure of its own.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          req_any
);
  int unsigned j;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j[PW-1:0];
      end
    end
  end

  assign req_any = |req;
endmodule

// File: rtl/fetch_redirect_arbiter.sv
// Round-robin arbiter of N_SRC redirect sources into one send/recv slot towards fetch.
// Latency req -> out_can_recv 1 cycle; grants only when slot empty or drained this cycle.
// Optional REDIRECT_MERGE_EN: equal-PC requesters granted together, masks ORed.
module fetch_redirect_arbiter
  import fetch_redirect_arbiter_pkg::*;
#(
  parameter int N_SRC  = N_SRC_DEF,
  parameter int MASK_W = MASK_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_SRC-1:0]          req_valid,
  input  logic [N_SRC*MASK_W-1:0]   req_mask,
  input  logic [N_SRC*ADDR_W-1:0]   req_pc,
  output logic [N_SRC-1:0]          req_grant,
  input  logic                      flush,
  output logic                      out_can_recv,
  output logic [MASK_W-1:0]         out_mask,
  output logic [ADDR_W-1:0]         out_pc,
  input  logic                      fetch_recv,
  output logic [15:0]               drop_cnt
);
  localparam int PW = $clog2(N_SRC);

  slot_state_e      state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  redirect_pkt_t    pkt_q, pkt_d;
  logic [15:0]      drop_q, drop_d;

  logic [N_SRC-1:0] pick_gnt, grant_vec;
  logic [PW-1:0]    pick_idx;
  logic             pick_any, accept, load;
  execution_mask_t  merged_mask;
  memory_address_t  win_pc;

  rr_picker #(.N(N_SRC), .PW(PW)) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .req_any (pick_any)
  );

  assign accept = ((state_q == SLOT_EMPTY) || fetch_recv) && !flush;
  assign load   = accept && pick_any;
  assign win_pc = req_pc[pick_idx*ADDR_W +: ADDR_W];

  always_comb begin
    grant_vec   = pick_gnt;
    merged_mask = req_mask[pick_idx*MASK_W +: MASK_W];
`ifdef REDIRECT_MERGE_EN
    for (int i = 0; i < N_SRC; i++) begin
      if (req_valid[i] && (req_pc[i*ADDR_W +: ADDR_W] == win_pc)) begin
        grant_vec[i] = 1'b1;
        merged_mask  = merged_mask | req_mask[i*MASK_W +: MASK_W];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SLOT_EMPTY;
    else          state_q <= state_d;
  end

  // flush beats both refill and drain; fetch_recv on an empty slot is ignored.
  always_comb begin
    state_d = state_q;
    if (flush)           state_d = SLOT_EMPTY;
    else if (load)       state_d = SLOT_FULL;
    else if (fetch_recv) state_d = SLOT_EMPTY;
  end

  always_comb begin
    req_grant    = (load && reset_n) ? grant_vec : '0;
    out_can_recv = (state_q == SLOT_FULL);
  end

  always_comb begin
    pkt_d  = pkt_q;
    ptr_d  = ptr_q;
    drop_d = drop_q;
    if (load) begin
      pkt_d.exec_mask = merged_mask;
      pkt_d.newpc     = win_pc;
      ptr_d = (pick_idx == PW'(N_SRC - 1)) ? '0 : pick_idx + PW'(1);
    end
    if (flush && (state_q == SLOT_FULL) && !fetch_recv)
      drop_d = sat_inc16(drop_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      pkt_q  <= pkt_d;
      drop_q <= drop_d;
    end
  end

  assign out_mask = pkt_q.exec_mask;
  assign out_pc   = pkt_q.newpc;
  assign drop_cnt = drop_q;

  assert property (@(posedge clk) disable iff (!reset_n)
                   !(fetch_recv && (state_q == SLOT_EMPTY)))
    else $error("fetch_recv while redirect slot empty");
endmodule

// File: tb/tb_fetch_redirect_arbiter.sv
// Directed vector table plus hand sequences for merge and async reset of fetch_redirect_arbiter.
module tb_fetch_redirect_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid, req_grant;
  logic [N*32-1:0] req_mask, req_pc;
  logic            flush, fetch_recv, out_can_recv;
  logic [31:0]     out_mask, out_pc;
  logic [15:0]     drop_cnt;

  logic [31:0] src_pc   [N];
  logic [31:0] src_mask [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_pc   = '0;
    req_mask = '0;
    for (int i = 0; i < N; i++) begin
      req_pc[i*32 +: 32]   = src_pc[i];
      req_mask[i*32 +: 32] = src_mask[i];
    end
  end

  fetch_redirect_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_mask     (req_mask),
    .req_pc       (req_pc),
    .req_grant    (req_grant),
    .flush        (flush),
    .out_can_recv (out_can_recv),
    .out_mask     (out_mask),
    .out_pc       (out_pc),
    .fetch_recv   (fetch_recv),
    .drop_cnt     (drop_cnt)
  );

  typedef struct {
    logic [3:0]  vld;
    logic        fl;
    logic        rv;
    logic [3:0]  exp_gnt;
    logic        exp_full;
    logic [31:0] exp_pc;
    logic [31:0] exp_mask;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(input logic [3:0] v, input logic f, input logic r,
                              input logic [3:0] g, input logic full,
                              input logic [31:0] pc, input logic [31:0] m,
                              input logic [15:0] d);
    vec_t x;
    x.vld = v; x.fl = f; x.rv = r; x.exp_gnt = g; x.exp_full = full;
    x.exp_pc = pc; x.exp_mask = m; x.exp_drop = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    // src0 0x80/0xF, src1 0xC0/zero mask, src2 0x100, src3 0x140
    src_pc[0] = 32'h80;  src_mask[0] = 32'h0000_000F;
    src_pc[1] = 32'hC0;  src_mask[1] = 32'h0000_0000;
    src_pc[2] = 32'h100; src_mask[2] = 32'hFFFF_0000;
    src_pc[3] = 32'h140; src_mask[3] = 32'h8000_0001;

    vt[0]  = mk(4'b1111, 0, 0, 4'b0001, 1, 32'h80,  32'h0000_000F, 0);
    vt[1]  = mk(4'b1111, 0, 1, 4'b0010, 1, 32'hC0,  32'h0000_0000, 0);
    vt[2]  = mk(4'b1111, 0, 1, 4'b0100, 1, 32'h100, 32'hFFFF_0000, 0);
    vt[3]  = mk(4'b1111, 0, 1, 4'b1000, 1, 32'h140, 32'h8000_0001, 0);
    vt[4]  = mk(4'b1111, 0, 1, 4'b0001, 1, 32'h80,  32'h0000_000F, 0);
    vt[5]  = mk(4'b0000, 0, 1, 4'b0000, 0, 32'h0,   32'h0,         0);
    vt[6]  = mk(4'b0100, 0, 0, 4'b0100, 1, 32'h100, 32'hFFFF_0000, 0);
    for (int k = 7; k <= 11; k++)
      vt[k] = mk(4'b0010, 0, 0, 4'b0000, 1, 32'h100, 32'hFFFF_0000, 0);
    vt[12] = mk(4'b0010, 0, 1, 4'b0010, 1, 32'hC0,  32'h0000_0000, 0);
    vt[13] = mk(4'b0000, 1, 0, 4'b0000, 0, 32'h0,   32'h0,         1);
    vt[14] = mk(4'b1000, 0, 0, 4'b1000, 1, 32'h140, 32'h8000_0001, 1);
    vt[15] = mk(4'b0000, 1, 1, 4'b0000, 0, 32'h0,   32'h0,         1);
    vt[16] = mk(4'b0001, 1, 0, 4'b0000, 0, 32'h0,   32'h0,         1);
    vt[17] = mk(4'b1000, 0, 0, 4'b1000, 1, 32'h140, 32'h8000_0001, 1);
    vt[18] = mk(4'b1000, 1, 0, 4'b0000, 0, 32'h0,   32'h0,         2);
    vt[19] = mk(4'b0000, 0, 0, 4'b0000, 0, 32'h0,   32'h0,         2);

    reset_n = 1'b0; req_valid = 4'b1111; flush = 1'b0; fetch_recv = 1'b0;
    #2;
    chk("reset grant", 32'(req_grant), 32'h0);
    chk("reset can_recv", 32'(out_can_recv), 32'h0);
    chk("reset mask", out_mask, 32'h0);
    chk("reset pc", out_pc, 32'h0);
    chk("reset drop", 32'(drop_cnt), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      req_valid = vt[k].vld; flush = vt[k].fl; fetch_recv = vt[k].rv;
      @(negedge clk);
      chk($sformatf("v%0d grant", k), 32'(req_grant), 32'(vt[k].exp_gnt));
      @(posedge clk); #1;
      chk($sformatf("v%0d can_recv", k), 32'(out_can_recv), 32'(vt[k].exp_full));
      if (vt[k].exp_full) begin
        chk($sformatf("v%0d pc", k), out_pc, vt[k].exp_pc);
        chk($sformatf("v%0d mask", k), out_mask, vt[k].exp_mask);
      end
      chk($sformatf("v%0d drop", k), 32'(drop_cnt), 32'(vt[k].exp_drop));
    end

    // Equal-PC requesters from src0 and src3, pointer at 0, slot empty.
    src_pc[0] = 32'h40; src_mask[0] = 32'h0F;
    src_pc[3] = 32'h40; src_mask[3] = 32'hF0;
    req_valid = 4'b1001; flush = 1'b0; fetch_recv = 1'b0;
    @(negedge clk);
`ifdef REDIRECT_MERGE_EN
    chk("merge grant", 32'(req_grant), 32'h9);
`else
    chk("merge grant", 32'(req_grant), 32'h1);
`endif
    @(posedge clk); #1;
    chk("merge can_recv", 32'(out_can_recv), 32'h1);
    chk("merge pc", out_pc, 32'h40);
`ifdef REDIRECT_MERGE_EN
    chk("merge mask", out_mask, 32'hFF);
    req_valid = 4'b0000; fetch_recv = 1'b1;
    @(negedge clk);
    chk("merge2 grant", 32'(req_grant), 32'h0);
    @(posedge clk); #1;
    chk("merge2 can_recv", 32'(out_can_recv), 32'h0);
    fetch_recv = 1'b0;
`else
    chk("merge mask", out_mask, 32'h0F);
    req_valid = 4'b1000; fetch_recv = 1'b1;
    @(negedge clk);
    chk("merge2 grant", 32'(req_grant), 32'h8);
    @(posedge clk); #1;
    chk("merge2 pc", out_pc, 32'h40);
    chk("merge2 mask", out_mask, 32'hF0);
`endif

    req_valid = 4'b0100;
    @(negedge clk);
    chk("fill grant", 32'(req_grant), 32'h4);
    @(posedge clk); #1;
    chk("fill can_recv", 32'(out_can_recv), 32'h1);
    chk("fill pc", out_pc, 32'h100);

    // Async reset between edges while the slot is full and a request is pending.
    fetch_recv = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset can_recv", 32'(out_can_recv), 32'h0);
    chk("areset grant", 32'(req_grant), 32'h0);
    chk("areset pc", out_pc, 32'h0);
    chk("areset mask", out_mask, 32'h0);
    chk("areset drop", 32'(drop_cnt), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1; req_valid = 4'b1111;
    @(negedge clk);
    chk("post-reset grant", 32'(req_grant), 32'h1);
    @(posedge clk); #1;
    chk("post-reset can_recv", 32'(out_can_recv), 32'h1);
    chk("post-reset pc", out_pc, 32'h40);
    chk("post-reset mask", out_mask, 32'h0F);
    req_valid = 4'b0000; fetch_recv = 1'b1;
    @(posedge clk); #1;
    chk("drain can_recv", 32'(out_can_recv), 32'h0);
    fetch_recv = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
